exe_muldiv_unit: RTL and testbench

EXE_MULDIV_UNIT -- requirements
Module: exe_muldiv_unit

---
 rtl/exe_muldiv_pkg.sv | 38 +++
 rtl/exe_muldiv_unit_md_iter.sv | 82 ++++++++
 rtl/exe_muldiv_unit.sv | 133 +++++++++++++
 tb/tb_exe_muldiv_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/exe_muldiv_pkg.sv
// Shared definitions for the multiply/divide execution unit.
//   - operation encodings carried on the 3-bit op bus
//   - FSM state enum
//   - helpers: counter width and op classification
package exe_muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   // 3'd6 and 3'd7 are NOPs

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_e;

   // Iteration counter width: ceil(log2(width)), at least one bit.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

   function automatic logic op_is_muldiv(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_div(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/exe_muldiv_unit_md_iter.sv
// Iterative multiply/divide datapath working on operand magnitudes.
//   clk       : clock
//   load      : capture operands (magnitudes + result sign flags)
//   step      : perform one shift-add (mult) or restoring (div) iteration
//   is_div    : operation class captured on load
//   is_signed : operands are two's complement
//   a, b      : operands (multiplicand/dividend, multiplier/divisor)
//   res_hi    : sign-corrected product upper half / remainder
//   res_lo    : sign-corrected product lower half / quotient
// upper/lower form one 2*WIDTH shift register: for multiply it is
// {partial product, remaining multiplier bits}; for divide it is
// {partial remainder, dividend bits shifting out / quotient bits shifting in}.
module md_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   logic [WIDTH-1:0]   upper, lower, opb;
   logic               div_q, neg_q, neg_r;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, rem_sh, rem_sub;
   logic [2*WIDTH-1:0] prod, prod_fix;

   assign a_neg = is_signed & a[WIDTH-1];
   assign b_neg = is_signed & b[WIDTH-1];
   // The most-negative value keeps its bit pattern as an unsigned magnitude.
   assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
   assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;

   assign mul_sum = {1'b0, upper} + (lower[0] ? {1'b0, opb} : '0);
   assign rem_sh  = {upper, lower[WIDTH-1]};
   // Remainder stays below the divisor, so bit WIDTH of the difference
   // is a reliable borrow indicator.
   assign rem_sub = rem_sh - {1'b0, opb};

   always_ff @(posedge clk) begin
      if (load) begin
         upper <= '0;
         lower <= a_mag;
         opb   <= b_mag;
         div_q <= is_div;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
      end else if (step) begin
         if (div_q) begin
            if (!rem_sub[WIDTH]) begin
               upper <= rem_sub[WIDTH-1:0];
               lower <= {lower[WIDTH-2:0], 1'b1};
            end else begin
               upper <= rem_sh[WIDTH-1:0];
               lower <= {lower[WIDTH-2:0], 1'b0};
            end
         end else begin
            upper <= mul_sum[WIDTH:1];
            lower <= {mul_sum[0], lower[WIDTH-1:1]};
         end
      end
   end

   assign prod     = {upper, lower};
   assign prod_fix = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;

   always_comb begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
      if (div_q) begin
         res_hi = neg_r ? (~upper + WIDTH'(1)) : upper;
         res_lo = neg_q ? (~lower + WIDTH'(1)) : lower;
      end
   end

endmodule

// File: rtl/exe_muldiv_unit.sv
// Multiply/divide execution unit with HI/LO result registers.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start, op    : request strobe and operation (exe_muldiv_pkg encodings)
//   rs_data      : operand A / MTHI-MTLO source
//   rt_data      : operand B
//   busy         : iterative operation in progress (RUN or FINISH)
//   done         : one-cycle pulse, HI/LO hold a fresh mult/div result
//   hi, lo       : result registers
//   div_zero     : last divide had a zero divisor (cleared by next mult/div start)
//   dbg_state    : current FSM state
// Handshake: start is sampled only while busy=0; a mult/div start is
// accepted on that edge and busy rises for the whole operation. Starts
// while busy=1 are dropped (no queueing). All outputs are registered.
module exe_muldiv_unit
   import exe_muldiv_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter bit EARLY_DIV0 = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero,
   output logic [1:0]       dbg_state
);

   localparam int             CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   state_e            state, state_next;
   logic [CW-1:0]     cnt;
   logic              load, step, fin;
   logic              div_by_zero;
   logic              dz_q;
   logic [WIDTH-1:0]  rs_q;
   logic [WIDTH-1:0]  res_hi, res_lo;

   assign div_by_zero = op_is_div(op) && (rt_data == '0);

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      fin        = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start && op_is_muldiv(op)) begin
               load = 1'b1;
               if (EARLY_DIV0 && div_by_zero) state_next = ST_FINISH;
               else                           state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (cnt == CNT_LAST) state_next = ST_FINISH;
         end
         ST_FINISH: begin
            fin        = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Counter parks at WIDTH-1 on the last RUN edge and is cleared in FINISH.
   always_ff @(posedge clock) begin
      if (reset || load || fin)          cnt <= '0;
      else if (step && cnt != CNT_LAST)  cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         dz_q     <= 1'b0;
         rs_q     <= '0;
      end else begin
         done <= 1'b0;
         if (state == ST_IDLE && start) begin
            if (op_is_muldiv(op)) begin
               div_zero <= 1'b0;
               dz_q     <= div_by_zero;
               rs_q     <= rs_data;
            end else if (op == OP_MTHI) begin
               hi <= rs_data;
            end else if (op == OP_MTLO) begin
               lo <= rs_data;
            end
         end
         if (fin) begin
            done <= 1'b1;
            if (dz_q) begin
               hi       <= rs_q;
               lo       <= '1;
               div_zero <= 1'b1;
            end else begin
               hi <= res_hi;
               lo <= res_lo;
            end
         end
      end
   end

   md_iter #(.WIDTH(WIDTH)) u_md_iter (
      .clk       (clock),
      .load      (load),
      .step      (step),
      .is_div    (op_is_div(op)),
      .is_signed (op_is_signed(op)),
      .a         (rs_data),
      .b         (rt_data),
      .res_hi    (res_hi),
      .res_lo    (res_lo)
   );

   assign busy      = (state != ST_IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed bench for exe_muldiv_unit at WIDTH 8 (full-latency divide by
// zero), 32 (early divide by zero) and 64.
module tb_exe_muldiv_unit;
   import exe_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start8 = 1'b0, start32 = 1'b0, start64 = 1'b0;
   logic [2:0]  op = 3'd7;
   logic [63:0] rs = '0, rt = '0;
   int          sel = 32;
   int          n_checks = 0, n_errors = 0;

   logic        busy8, done8, dz8, busy32, done32, dz32, busy64, done64, dz64;
   logic [7:0]  hi8, lo8;
   logic [31:0] hi32, lo32;
   logic [63:0] hi64, lo64;
   logic [1:0]  st8, st32, st64;

   logic        cur_busy, cur_done, cur_dz;
   logic [63:0] cur_hi, cur_lo;
   logic [1:0]  cur_st;

   always #5 clk = ~clk;

   exe_muldiv_unit #(.WIDTH(8), .EARLY_DIV0(1'b0)) dut8 (
      .clock(clk), .reset(reset), .start(start8), .op(op), .rs_data(rs[7:0]), .rt_data(rt[7:0]),
      .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8), .dbg_state(st8));
   exe_muldiv_unit #(.WIDTH(32), .EARLY_DIV0(1'b1)) dut32 (
      .clock(clk), .reset(reset), .start(start32), .op(op), .rs_data(rs[31:0]), .rt_data(rt[31:0]),
      .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_zero(dz32), .dbg_state(st32));
   exe_muldiv_unit #(.WIDTH(64), .EARLY_DIV0(1'b1)) dut64 (
      .clock(clk), .reset(reset), .start(start64), .op(op), .rs_data(rs), .rt_data(rt),
      .busy(busy64), .done(done64), .hi(hi64), .lo(lo64), .div_zero(dz64), .dbg_state(st64));

   always_comb begin
      cur_busy = busy64; cur_done = done64; cur_dz = dz64;
      cur_hi = hi64; cur_lo = lo64; cur_st = st64;
      if (sel == 8) begin
         cur_busy = busy8; cur_done = done8; cur_dz = dz8;
         cur_hi = 64'(hi8); cur_lo = 64'(lo8); cur_st = st8;
      end else if (sel == 32) begin
         cur_busy = busy32; cur_done = done32; cur_dz = dz32;
         cur_hi = 64'(hi32); cur_lo = 64'(lo32); cur_st = st32;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input int w, input logic v);
      start8  = (w == 8)  && v;
      start32 = (w == 32) && v;
      start64 = (w == 64) && v;
   endtask

   // Independent reference: wide signed/unsigned arithmetic.
   function automatic logic [127:0] ref_model(input logic [2:0] o, input logic [63:0] a,
                                              input logic [63:0] b, input int w);
      logic [127:0]        mask, ua, ub, h, l;
      logic signed [127:0] sa, sb, p;
      mask = (128'd1 << w) - 128'd1;
      ua = {64'd0, a} & mask;
      ub = {64'd0, b} & mask;
      sa = ua; if (ua[w-1]) sa = ua - (128'd1 << w);
      sb = ub; if (ub[w-1]) sb = ub - (128'd1 << w);
      h = '0; l = '0;
      case (o)
         OP_MULT:  begin p = sa * sb; h = (p >> w) & mask; l = p & mask; end
         OP_MULTU: begin p = ua * ub; h = (p >> w) & mask; l = p & mask; end
         OP_DIV: begin
            if (ub == 0) begin h = ua; l = mask; end
            else begin p = sa % sb; h = p & mask; p = sa / sb; l = p & mask; end
         end
         OP_DIVU: begin
            if (ub == 0) begin h = ua; l = mask; end
            else begin h = ua % ub; l = ua / ub; end
         end
         default: ;
      endcase
      return {h[63:0], l[63:0]};
   endfunction

   task automatic run_md(input int w, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] eh, input logic [63:0] el, input int lat_exp,
                         input logic dz_exp, input string tag);
      logic [63:0] hi0, lo0;
      int lat;
      @(negedge clk);
      sel = w; op = o; rs = a; rt = b; set_start(w, 1'b1);
      @(posedge clk); #1;
      set_start(w, 1'b0);
      op = OP_MTHI; rs = ~a; rt = ~b;   // later input changes must not matter
      hi0 = cur_hi; lo0 = cur_lo;
      chk({tag, ".busy"}, 64'(cur_busy), 64'd1);
      chk({tag, ".dz_clr"}, 64'(cur_dz), 64'd0);
      lat = 0;
      while (!cur_done && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 4 && lat_exp > 4) chk({tag, ".hold"}, cur_hi ^ hi0 | cur_lo ^ lo0, 64'd0);
      end
      chk({tag, ".lat"}, 64'(lat), 64'(lat_exp));
      chk({tag, ".hi"}, cur_hi, eh);
      chk({tag, ".lo"}, cur_lo, el);
      chk({tag, ".dz"}, 64'(cur_dz), 64'(dz_exp));
      @(posedge clk); #1;
      chk({tag, ".done_drop"}, 64'(cur_done), 64'd0);
      chk({tag, ".idle"}, 64'(cur_busy), 64'd0);
   endtask

   task automatic run_ref(input int w, input logic [2:0] o, input logic [63:0] a,
                          input logic [63:0] b, input string tag);
      logic [127:0] m;
      logic [63:0]  mask;
      logic         dz;
      m = ref_model(o, a, b, w);
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      dz = op_is_div(o) && ((b & mask) == 64'd0);
      run_md(w, o, a, b, m[127:64], m[63:0], (dz && w != 8) ? 1 : w + 1, dz, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic seen_done;
      int   ws[3];
      ws = '{8, 32, 64};
      // reset state
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      foreach (ws[i]) begin
         sel = ws[i]; #1;
         chk($sformatf("rst%0d.state", ws[i]), 64'(cur_st), 64'(ST_IDLE));
         chk($sformatf("rst%0d.hilo", ws[i]), cur_hi | cur_lo, 64'd0);
         chk($sformatf("rst%0d.flags", ws[i]), {61'd0, cur_busy, cur_done, cur_dz}, 64'd0);
      end
      @(negedge clk); reset = 1'b0;

      // WIDTH=32 directed vectors
      run_md(32, OP_MULT,  64'hFFFF_FFFD, 64'd7, 64'hFFFF_FFFF, 64'hFFFF_FFEB, 33, 1'b0, "w32_mult");
      run_md(32, OP_MULTU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 64'h0000_0001, 33, 1'b0, "w32_multu");
      run_md(32, OP_DIV,   64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFD, 33, 1'b0, "w32_div");
      run_md(32, OP_DIV,   64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 64'h8000_0000, 33, 1'b0, "w32_divmin");
      run_md(32, OP_DIVU,  64'd5, 64'd0, 64'd5, 64'hFFFF_FFFF, 1, 1'b1, "w32_div0");

      // MTHI leaves div_zero alone, no busy/done
      @(negedge clk); sel = 32; op = OP_MTHI; rs = 64'hAA; start32 = 1'b1;
      @(posedge clk); #1; start32 = 1'b0;
      chk("mthi.hi", cur_hi, 64'hAA);
      chk("mthi.dz", 64'(cur_dz), 64'd1);
      chk("mthi.busy_done", {62'd0, cur_busy, cur_done}, 64'd0);

      // NOP op leaves HI/LO untouched
      @(negedge clk); op = 3'd6; rs = 64'h55; start32 = 1'b1;
      @(posedge clk); #1; start32 = 1'b0;
      chk("nop.hi", cur_hi, 64'hAA);
      chk("nop.lo", cur_lo, 64'hFFFF_FFFF);
      chk("nop.busy", 64'(cur_busy), 64'd0);

      // next mult start clears div_zero (checked at accept inside run_md)
      run_md(32, OP_MULT, 64'd6, 64'hFFFF_FFFE, 64'hFFFF_FFFF, 64'hFFFF_FFF4, 33, 1'b0, "w32_mult_clr");

      // abort: start, ignored restart at edge 10, reset at edge 20
      @(negedge clk); op = OP_MULT; rs = 64'd5; rt = 64'd6; start32 = 1'b1;
      @(posedge clk); #1; start32 = 1'b0;               // edge 0
      repeat (9) @(posedge clk); #1;                      // edge 9
      op = OP_DIVU; rs = 64'd100; rt = 64'd0; start32 = 1'b1;
      @(posedge clk); #1; start32 = 1'b0;               // edge 10
      chk("abort.busy10", 64'(cur_busy), 64'd1);
      chk("abort.dz10", 64'(cur_dz), 64'd0);
      repeat (9) @(posedge clk); #1;                      // edge 19
      reset = 1'b1;
      @(posedge clk); #1;                                 // edge 20
      reset = 1'b0;
      chk("abort.busy", 64'(cur_busy), 64'd0);
      chk("abort.hilo", cur_hi | cur_lo, 64'd0);
      seen_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (cur_done) seen_done = 1'b1;
      end
      chk("abort.no_done", 64'(seen_done), 64'd0);
      @(negedge clk); op = OP_MTLO; rs = 64'h1234; start32 = 1'b1;
      @(posedge clk); #1; start32 = 1'b0;
      chk("mtlo.lo", cur_lo, 64'h1234);
      chk("mtlo.hi", cur_hi, 64'h0);

      // WIDTH=8 (full-latency divide by zero) and WIDTH=64 against the model
      foreach (ws[i]) begin
         if (ws[i] != 32) begin
            run_ref(ws[i], OP_MULT,  64'hFFFF_FFFF_FFFF_FFFD, 64'd7, $sformatf("w%0d_mult", ws[i]));
            run_ref(ws[i], OP_MULTU, '1, '1, $sformatf("w%0d_multu", ws[i]));
            run_ref(ws[i], OP_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, $sformatf("w%0d_div", ws[i]));
            run_ref(ws[i], OP_DIV,   64'd1 << (ws[i] - 1), '1, $sformatf("w%0d_divmin", ws[i]));
            run_ref(ws[i], OP_DIVU,  64'h00C3_5A17_9E42_00B7, 64'h0000_0000_0000_0013, $sformatf("w%0d_divu", ws[i]));
            run_ref(ws[i], OP_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd0, $sformatf("w%0d_div0", ws[i]));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
